// File: rtl/div3_bit_serializer.sv
// MSB-first parallel-to-serial transmitter with framing strobes and a running mod-3 remainder.
// Optional remainder tracking is enabled by defining DIV3_SER_CHECK_EN.
module div3_bit_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_in,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         en,
  output logic         x,
  output logic         x_valid,
  output logic         frame_start,
  output logic         frame_end,
  output logic         done,
  output logic [1:0]   rem,
  output logic         div3
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           in_shift_s;
  logic           load_s;
  logic           step_s;

  assign in_shift_s = (state_q == S_SHIFT);
  assign load_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign load_s     = load_ready && load_valid;
  assign step_s     = in_shift_s && en;

  assign x           = in_shift_s & shreg_q[W-1];
  assign x_valid     = step_s;
  assign frame_start = step_s && (cnt_q == {CW{1'b0}});
  assign frame_end   = step_s && (cnt_q == LAST_IDX);
  assign done        = (state_q == S_DONE);

  // Next-state decode for the FSM, shift register and bit counter
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_valid) begin
          state_d = S_SHIFT;
          shreg_d = data_in;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (en) begin
          shreg_d = {shreg_q[W-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= {W{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DIV3_SER_CHECK_EN
  logic [1:0] rem_q, rem_d;

  // Appending bit b to a value with remainder r gives remainder (2r + b) mod 3
  function automatic logic [1:0] rem_step(input logic [1:0] r, input logic b);
    logic [1:0] res;
    case ({r, b})
      3'b000:  res = 2'd0;
      3'b001:  res = 2'd1;
      3'b010:  res = 2'd2;
      3'b011:  res = 2'd0;
      3'b100:  res = 2'd1;
      3'b101:  res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  // Remainder clears on load, advances per shifted bit, otherwise holds
  always_comb begin
    rem_d = rem_q;
    if (load_s) begin
      rem_d = 2'd0;
    end else if (step_s) begin
      rem_d = rem_step(rem_q, shreg_q[W-1]);
    end else begin
      rem_d = rem_q;
    end
  end

  // Remainder register
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= 2'd0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign rem  = rem_q;
  assign div3 = (rem_q == 2'd0);
`else
  assign rem  = 2'b00;
  assign div3 = 1'b0;
`endif

endmodule

// File: tb/tb_div3_bit_serializer.sv
// Randomized self-checking bench for div3_bit_serializer; the reference is the arithmetic
// value of the word prefix sent so far, taken mod 3.
module tb_div3_bit_serializer;

  localparam int W = 8;
`ifdef DIV3_SER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         load_ready;
  logic         en;
  logic         x;
  logic         x_valid;
  logic         frame_start;
  logic         frame_end;
  logic         done;
  logic [1:0]   rem;
  logic         div3;

  int n_cmp = 0;
  int n_err = 0;

  div3_bit_serializer #(.W(W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .en(en), .x(x), .x_valid(x_valid),
    .frame_start(frame_start), .frame_end(frame_end), .done(done),
    .rem(rem), .div3(div3)
  );

  always #5 clk = ~clk;

  // Remainder of the first k bits (MSB first) of w, read as a binary number.
  function automatic logic [1:0] model_rem(input logic [W-1:0] w, input int k);
    int unsigned wv;
    wv = w;
    if (!CHK) return 2'b00;
    return 2'((wv >> (W - k)) % 3);
  endfunction

  function automatic logic model_div3(input logic [W-1:0] w, input int k);
    if (!CHK) return 1'b0;
    return (model_rem(w, k) == 2'b00);
  endfunction

  // Loads w (callable from IDLE or DONE), shifts it out and stops mid-way through the DONE cycle.
  task automatic run_frame(input logic [W-1:0] w, input int stall_at, input int stall_len,
                           input bit rand_en, input string tag);
    int k;
    int cyc;
    int stalled;
    bit e;
    logic [8:0] obs;
    logic [8:0] expv;
    data_in = w;
    load_valid = 1'b1;
    en = 1'($urandom_range(0, 1));
    #1;
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_accept: load_ready=%b required 1", tag, load_ready);
    end
    @(posedge clk); #1;
    k = 0; cyc = 0; stalled = 0;
    while (k < W && cyc < 200) begin
      if (rand_en) e = ($urandom_range(0, 3) != 0);
      else if (k == stall_at && stalled < stall_len) begin e = 1'b0; stalled++; end
      else e = 1'b1;
      en = e;
      load_valid = 1'($urandom_range(0, 1));
      data_in = W'($urandom);
      @(negedge clk);
      obs  = {x, x_valid, frame_start, frame_end, done, load_ready, rem, div3};
      expv = {w[W-1-k], e, e && (k == 0), e && (k == W - 1), 1'b0, 1'b0,
              model_rem(w, k), model_div3(w, k)};
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL %s_bit%0d: {x,xv,fs,fe,done,rdy,rem,div3}=%b required %b", tag, k, obs, expv);
      end
      @(posedge clk); #1;
      if (e) k++;
      cyc++;
    end
    if (k < W) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: only %0d of %0d bits shifted", tag, k, W);
    end
    load_valid = 1'b0;
    en = 1'($urandom_range(0, 1));
    @(negedge clk);
    obs  = {x, x_valid, frame_start, frame_end, done, load_ready, rem, div3};
    expv = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, model_rem(w, W), model_div3(w, W)};
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s_done: {x,xv,fs,fe,done,rdy,rem,div3}=%b required %b", tag, obs, expv);
    end
  endtask

  // Leaves DONE without a new word; the remainder must hold in IDLE.
  task automatic go_idle(input logic [W-1:0] w, input string tag);
    logic [8:0] obs;
    logic [8:0] expv;
    load_valid = 1'b0;
    en = 1'b1;
    @(posedge clk); #1;
    obs  = {x, x_valid, frame_start, frame_end, done, load_ready, rem, div3};
    expv = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_rem(w, W), model_div3(w, W)};
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s_idle: {x,xv,fs,fe,done,rdy,rem,div3}=%b required %b", tag, obs, expv);
    end
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    logic [8:0] expv;
    rst = 1'b1; load_valid = 1'b1; en = 1'b1; data_in = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; load_valid = 1'b0;
    expv = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, CHK};
    for (int i = 0; i < 5; i++) begin
      en = 1'($urandom_range(0, 1));
      @(negedge clk);
      obs = {x, x_valid, frame_start, frame_end, done, load_ready, rem, div3};
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL reset_idle%0d: {x,xv,fs,fe,done,rdy,rem,div3}=%b required %b", i, obs, expv);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    run_frame(8'h06, -1, 0, 1'b0, "basic06");
    go_idle(8'h06, "basic06");
  endtask

  task automatic test_back_to_back();
    run_frame(8'h07, -1, 0, 1'b0, "b2b07");
    run_frame(8'h08, -1, 0, 1'b0, "b2b08");
    go_idle(8'h08, "b2b08");
  endtask

  task automatic test_stall();
    run_frame(8'hFF, 4, 3, 1'b0, "stallFF");
    go_idle(8'hFF, "stallFF");
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] w;
    logic [8:0] obs;
    logic [8:0] expv;
    w = 8'hA5;
    data_in = w; load_valid = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (x !== w[W-5] || x_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_bit4: x=%b xv=%b required %b 1", x, x_valid, w[W-5]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expv = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, CHK};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      obs = {x, x_valid, frame_start, frame_end, done, load_ready, rem, div3};
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL rstmid_after%0d: {x,xv,fs,fe,done,rdy,rem,div3}=%b required %b", i, obs, expv);
      end
      @(posedge clk); #1;
    end
    run_frame(8'h03, -1, 0, 1'b0, "rstmid03");
    go_idle(8'h03, "rstmid03");
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    bit in_done;
    in_done = 1'b0;
    for (int f = 0; f < 20; f++) begin
      w = W'($urandom);
      run_frame(w, -1, 0, 1'b1, "rand");
      if ($urandom_range(0, 1) == 0) go_idle(w, "rand");
    end
    go_idle(w, "rand_end");
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; en = 1'b0; data_in = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
